// File: rtl/cs_host_controller_if.sv
// Command/response port of the computational-storage host controller.
// Latency: none, wires only; the controller registers every output it drives.
// Backpressure: cmd_ready low holds the master off; a response is a one-cycle rsp_valid pulse.
interface cs_host_controller_if #(
  parameter int MEM_WIDTH     = 8,
  parameter int MEM_DEPTH     = 16,
  parameter int NO_OPERATIONS = 4
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int OW = $clog2(NO_OPERATIONS);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [OW-1:0]        cmd_op;
  logic [AW-1:0]        cmd_addA;
  logic [AW-1:0]        cmd_addB;
  logic [AW-1:0]        cmd_addC;
  logic [MEM_WIDTH-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic [MEM_WIDTH-1:0] rsp_rdata;
  logic                 rsp_err;

  // System/test master side
  modport master (
    output cmd_valid, cmd_op, cmd_addA, cmd_addB, cmd_addC, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Controller side
  modport slave (
    input  cmd_valid, cmd_op, cmd_addA, cmd_addB, cmd_addC, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/cs_host_controller.sv
// Host initiator for the computational-storage array: WRITE/READ/ADD/SUB over addA/addB/addC/op pins and shared DQ.
// Latency accept->rsp_valid: WRITE 3 (RD_LATENCY+5 with CS_HOST_WRITE_VERIFY_EN), READ RD_LATENCY+2, COMPUTE CMP_CYCLES+1.
// Backpressure: one command in flight, cmd_ready low while busy; cmd_valid while busy is ignored, not queued.
module cs_host_controller #(
  parameter int MEM_WIDTH     = 8,
  parameter int MEM_DEPTH     = 16,
  parameter int NO_OPERATIONS = 4,
  parameter int RD_LATENCY    = 1,   // >= 1
  parameter int CMP_CYCLES    = 1    // >= 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  cs_host_controller_if.slave              cmd,
  output logic [$clog2(MEM_DEPTH)-1:0]     addA,
  output logic [$clog2(MEM_DEPTH)-1:0]     addB,
  output logic [$clog2(MEM_DEPTH)-1:0]     addC,
  output logic [$clog2(NO_OPERATIONS)-1:0] operation_select,
  inout  wire  [MEM_WIDTH-1:0]             DQ
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int OW = $clog2(NO_OPERATIONS);

  // One down-counter serves both the read wait and the compute hold.
  localparam int CNT_MAX = (RD_LATENCY > CMP_CYCLES) ? RD_LATENCY : CMP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RD_LOAD  = CW'(RD_LATENCY - 1);
  localparam logic [CW-1:0] CMP_LOAD = CW'(CMP_CYCLES - 1);

  localparam logic [OW-1:0] OP_WRITE = OW'(0);
  localparam logic [OW-1:0] OP_READ  = OW'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_TURN,
    S_WR_DRIVE,
    S_VF_TURN,
    S_RD_WAIT,
    S_RD_CAPTURE,
    S_CMP_EXEC,
    S_DONE
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 dq_oe;
  logic [MEM_WIDTH-1:0] dq_dat;   // holds the latched write data for the whole command
`ifdef CS_HOST_WRITE_VERIFY_EN
  logic                 vf_q;     // current read is the readback of a write
`endif

  // The enable flop is asynchronously cleared, so reset releases DQ without waiting for a clock.
  assign DQ = dq_oe ? dq_dat : {MEM_WIDTH{1'bz}};

  // Command sequencer; every pin and response output is set on the transition into the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      dq_oe            <= 1'b0;
      dq_dat           <= '0;
      addA             <= '0;
      addB             <= '0;
      addC             <= '0;
      operation_select <= OP_READ;
      cmd.cmd_ready    <= 1'b1;
      cmd.rsp_valid    <= 1'b0;
      cmd.rsp_rdata    <= '0;
      cmd.rsp_err      <= 1'b0;
`ifdef CS_HOST_WRITE_VERIFY_EN
      vf_q             <= 1'b0;
`endif
    end else begin
      cmd.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            cmd.cmd_ready <= 1'b0;
`ifdef CS_HOST_WRITE_VERIFY_EN
            vf_q          <= 1'b0;
`endif
            if (cmd.cmd_op == OP_WRITE) begin
              // Drop READ first so the storage lets go of DQ before we drive it.
              state            <= S_WR_TURN;
              operation_select <= OP_WRITE;
              addC             <= cmd.cmd_addC;
              dq_dat           <= cmd.cmd_wdata;
            end else if (cmd.cmd_op == OP_READ) begin
              state <= S_RD_WAIT;
              addA  <= cmd.cmd_addA;
              cnt   <= RD_LOAD;
            end else if (int'(cmd.cmd_op) < NO_OPERATIONS) begin
              state            <= S_CMP_EXEC;
              operation_select <= cmd.cmd_op;
              addA             <= cmd.cmd_addA;
              addB             <= cmd.cmd_addB;
              addC             <= cmd.cmd_addC;
              cnt              <= CMP_LOAD;
            end else begin
              // Unknown opcode: pins stay parked, answer immediately with an error.
              state         <= S_DONE;
              cmd.rsp_valid <= 1'b1;
              cmd.rsp_err   <= 1'b1;
            end
          end
        end

        S_WR_TURN: begin
          state <= S_WR_DRIVE;
          dq_oe <= 1'b1;
        end

        S_WR_DRIVE: begin
          // Storage captured DQ on this edge; release the bus and go back to READ.
          dq_oe            <= 1'b0;
          operation_select <= OP_READ;
          addC             <= '0;
`ifdef CS_HOST_WRITE_VERIFY_EN
          state            <= S_VF_TURN;
          addA             <= addC;
          vf_q             <= 1'b1;
`else
          state            <= S_DONE;
          cmd.rsp_valid    <= 1'b1;
          cmd.rsp_err      <= 1'b0;
`endif
        end

`ifdef CS_HOST_WRITE_VERIFY_EN
        S_VF_TURN: begin
          // Bus turnaround back to the storage before the readback wait starts.
          state <= S_RD_WAIT;
          cnt   <= RD_LOAD;
        end
`endif

        S_RD_WAIT: begin
          if (cnt == '0) state <= S_RD_CAPTURE;
          else           cnt   <= cnt - 1'b1;
        end

        S_RD_CAPTURE: begin
          state         <= S_DONE;
          cmd.rsp_rdata <= DQ;
          cmd.rsp_valid <= 1'b1;
          addA          <= '0;
`ifdef CS_HOST_WRITE_VERIFY_EN
          cmd.rsp_err   <= vf_q && (DQ != dq_dat);
`else
          cmd.rsp_err   <= 1'b0;
`endif
        end

        S_CMP_EXEC: begin
          if (cnt == '0) begin
            state            <= S_DONE;
            operation_select <= OP_READ;
            addA             <= '0;
            addB             <= '0;
            addC             <= '0;
            cmd.rsp_valid    <= 1'b1;
            cmd.rsp_err      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DONE: begin
          state         <= S_IDLE;
          cmd.cmd_ready <= 1'b1;
        end

        default: begin
          state            <= S_IDLE;
          dq_oe            <= 1'b0;
          operation_select <= OP_READ;
          addA             <= '0;
          addB             <= '0;
          addC             <= '0;
          cmd.cmd_ready    <= 1'b1;
        end
      endcase
    end
  end

endmodule
